// File: rtl/bus_arb_nm.sv
// bus_arb_nm: shared-bus arbiter and slave decoder for N_MST masters and
// N_SLV slaves. Address and data phases are pipelined one transfer apart.
// Arbitration is round-robin, with locked sequences and SPLIT handling
// through a per-master split mask.
//
// Ports:
//   CLK, RST      clock; asynchronous active-high reset
//   HREQ, HLOCK   per-master request / locked-sequence request
//   HADDR_M       packed master addresses, master i at [i*AW +: AW]
//   HWRITE_M      master write flags
//   HWDATA_M      packed master write data
//   HRDATA_S      packed slave read data
//   HRESP_S       packed slave responses (2 bits per slave)
//   HREADY_S      slave ready flags
//   HSPLIT        per-master un-split pulses from the slaves
//   HGRANT, HMAS  registered one-hot grant and index of the granted master
//   MLOCK         registered: the current grant is locked
//   HADDR, HWRITE, HSEL  address-phase bus and one-hot slave select
//   HWDATA, HRDATA, HRESP, HREADY  data-phase bus; HREADY gates all advances
module bus_arb_nm #(
  parameter  int N_MST = 4,
  parameter  int N_SLV = 4,
  parameter  int AW    = 16,
  parameter  int DW    = 32,
  localparam int MW    = $clog2(N_MST),
  localparam int SW    = $clog2(N_SLV)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [N_MST-1:0]    HREQ,
  input  logic [N_MST-1:0]    HLOCK,
  input  logic [N_MST*AW-1:0] HADDR_M,
  input  logic [N_MST-1:0]    HWRITE_M,
  input  logic [N_MST*DW-1:0] HWDATA_M,
  input  logic [N_SLV*DW-1:0] HRDATA_S,
  input  logic [N_SLV*2-1:0]  HRESP_S,
  input  logic [N_SLV-1:0]    HREADY_S,
  input  logic [N_MST-1:0]    HSPLIT,
  output logic [N_MST-1:0]    HGRANT,
  output logic [MW-1:0]       HMAS,
  output logic                MLOCK,
  output logic [AW-1:0]       HADDR,
  output logic                HWRITE,
  output logic [N_SLV-1:0]    HSEL,
  output logic [DW-1:0]       HWDATA,
  output logic [DW-1:0]       HRDATA,
  output logic [1:0]          HRESP,
  output logic                HREADY
);

  localparam logic [1:0] RESP_SPLIT = 2'b11;

  logic [N_MST-1:0] split_mask;
  logic [N_MST-1:0] split_set;
  logic [N_MST-1:0] split_nxt;
  logic [N_MST-1:0] eligible;
  logic [N_MST-1:0] grant_nxt;
  logic [MW-1:0]    mas_nxt;
  logic             dvld;
  logic [MW-1:0]    dmas;
  logic [SW-1:0]    dslv;
  logic             addr_active;
  logic [SW-1:0]    addr_slv;
  logic             split_done;
  logic             force_rearb;
  logic             hold_lock;

  // Address phase: everything is muxed from the registered HMAS.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    HSEL        = '0;
    HADDR       = HADDR_M[HMAS*AW +: AW];
    HWRITE      = HWRITE_M[HMAS];
    addr_active = HREQ[HMAS] & ~split_mask[HMAS];
    addr_slv    = HADDR[AW-1 -: SW];
    if (addr_active) HSEL[addr_slv] = 1'b1;
  end

  // Data phase: an idle data phase reports ready/OKAY so the pipeline advances.
  always_comb begin
    HWDATA = HWDATA_M[dmas*DW +: DW];
    HRDATA = '0;
    HRESP  = 2'b00;
    HREADY = 1'b1;
    if (dvld) begin
      HRDATA = HRDATA_S[dslv*DW +: DW];
      HRESP  = HRESP_S[dslv*2 +: 2];
      HREADY = HREADY_S[dslv];
    end
  end

  // Split bookkeeping. A set needs a completed SPLIT (HREADY=1); an HSPLIT
  // clear is honoured on every edge, and the set wins when both coincide.
  always_comb begin
    split_set  = '0;
    split_done = dvld & HREADY & (HRESP == RESP_SPLIT);
    if (split_done) split_set[dmas] = 1'b1;
    split_nxt   = (split_mask & ~HSPLIT) | split_set;
    force_rearb = split_done && (dmas == HMAS);
    // A lock keeps the grant only while the holder still asks for it and has
    // not just been split.
    hold_lock   = HLOCK[HMAS] & ~split_mask[HMAS] & ~force_rearb;
    // A master split on this edge must not win the re-arbitration.
    eligible    = HREQ & ~split_nxt;
  end

  // Round-robin search starting after the holder; the holder is tried last,
  // and master 0 is the default when nobody is eligible.
  always_comb begin
    int  idx;
    logic found;
    idx       = 0;
    found     = 1'b0;
    mas_nxt   = '0;
    grant_nxt = '0;
    for (int k = 1; k <= N_MST; k++) begin
      idx = (int'(HMAS) + k) % N_MST;
      if (!found && eligible[idx]) begin
        mas_nxt = MW'(idx);
        found   = 1'b1;
      end
    end
    grant_nxt[mas_nxt] = 1'b1;
  end

  // NOTE: state is updated only with non-blocking assignments so all
  // registers sample the values from before the edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      HGRANT     <= {{(N_MST-1){1'b0}}, 1'b1};
      HMAS       <= '0;
      MLOCK      <= 1'b0;
      split_mask <= '0;
      dvld       <= 1'b0;
      dmas       <= '0;
      dslv       <= '0;
    end else begin
      split_mask <= split_nxt;
      if (HREADY) begin
        dvld <= addr_active;
        dmas <= HMAS;
        dslv <= addr_slv;
        if (hold_lock) begin
          MLOCK <= 1'b1;
        end else begin
          MLOCK  <= 1'b0;
          HMAS   <= mas_nxt;
          HGRANT <= grant_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_arb_nm.sv
// Directed testbench for bus_arb_nm (4 masters, 4 slaves, AW=16, DW=32).
// Master i drives address i<<14 (so it targets slave i) and write data
// 32'hA0A0_000i; slave j returns read data 32'h5000_000j.
module tb_bus_arb_nm;

  localparam int N_MST = 4;
  localparam int N_SLV = 4;
  localparam int AW    = 16;
  localparam int DW    = 32;

  logic                CLK = 1'b0;
  logic                RST;
  logic [N_MST-1:0]    HREQ, HLOCK, HWRITE_M, HSPLIT;
  logic [N_MST*AW-1:0] HADDR_M;
  logic [N_MST*DW-1:0] HWDATA_M;
  logic [N_SLV*DW-1:0] HRDATA_S;
  logic [N_SLV*2-1:0]  HRESP_S;
  logic [N_SLV-1:0]    HREADY_S;
  logic [N_MST-1:0]    HGRANT;
  logic [1:0]          HMAS;
  logic                MLOCK;
  logic [AW-1:0]       HADDR;
  logic                HWRITE;
  logic [N_SLV-1:0]    HSEL;
  logic [DW-1:0]       HWDATA, HRDATA;
  logic [1:0]          HRESP;
  logic                HREADY;

  int checks = 0;
  int errors = 0;

  bus_arb_nm #(.N_MST(N_MST), .N_SLV(N_SLV), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RST(RST), .HREQ(HREQ), .HLOCK(HLOCK), .HADDR_M(HADDR_M),
    .HWRITE_M(HWRITE_M), .HWDATA_M(HWDATA_M), .HRDATA_S(HRDATA_S),
    .HRESP_S(HRESP_S), .HREADY_S(HREADY_S), .HSPLIT(HSPLIT),
    .HGRANT(HGRANT), .HMAS(HMAS), .MLOCK(MLOCK), .HADDR(HADDR),
    .HWRITE(HWRITE), .HSEL(HSEL), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HRESP(HRESP), .HREADY(HREADY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_resp(input int s, input logic [1:0] r);
    HRESP_S[s*2 +: 2] = r;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RST      = 1'b1;
    HREQ     = '0;
    HLOCK    = '0;
    HSPLIT   = '0;
    HWRITE_M = 4'b1010;
    HRESP_S  = '0;
    HREADY_S = 4'hF;
    for (int i = 0; i < N_MST; i++) begin
      HADDR_M[i*AW +: AW]  = AW'(i << 14);
      HWDATA_M[i*DW +: DW] = 32'hA0A0_0000 + DW'(i);
    end
    for (int j = 0; j < N_SLV; j++)
      HRDATA_S[j*DW +: DW] = 32'h5000_0000 + DW'(j);

    // Reset, idle
    repeat (3) @(posedge CLK);
    #1;
    check("rst_grant", HGRANT, 4'b0001);
    check("rst_mas",   HMAS,   0);
    check("rst_ready", HREADY, 1);
    check("rst_resp",  HRESP,  0);
    check("rst_sel",   HSEL,   0);
    check("rst_lock",  MLOCK,  0);
    RST = 1'b0;
    tick();

    // Round-robin with all masters requesting
    HREQ = 4'hF;
    #1 check("rr_sel0", HSEL, 4'b0001);
    tick();
    check("rr_mas1",   HMAS,   1);
    check("rr_grant1", HGRANT, 4'b0010);
    check("rr_addr1",  HADDR,  16'h4000);
    check("rr_sel1",   HSEL,   4'b0010);
    check("rr_write1", HWRITE, 1);
    check("rr_wdata0", HWDATA, 32'hA0A0_0000);
    tick();
    check("rr_mas2",   HMAS,   2);
    check("rr_wdata1", HWDATA, 32'hA0A0_0001);
    check("rr_rdata1", HRDATA, 32'h5000_0001);
    tick();
    check("rr_mas3", HMAS, 3);
    tick();
    check("rr_mas0", HMAS, 0);
    HREQ = '0;
    tick();
    tick();
    check("idle_mas",   HMAS,   0);
    check("idle_grant", HGRANT, 4'b0001);
    check("idle_sel",   HSEL,   0);

    // Wait states on slave 2
    HREQ = 4'b0100;
    tick();
    check("ws_mas",  HMAS,  2);
    check("ws_addr", HADDR, 16'h8000);
    check("ws_sel",  HSEL,  4'b0100);
    tick();
    HREADY_S = 4'b1011;
    HREQ     = 4'b1100;
    #1 check("ws_ready_lo", HREADY, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("ws_hold_mas",   HMAS,   2);
      check("ws_hold_grant", HGRANT, 4'b0100);
      check("ws_hold_addr",  HADDR,  16'h8000);
      check("ws_hold_ready", HREADY, 0);
    end
    HREADY_S = 4'hF;
    #1;
    check("ws_ready_hi", HREADY, 1);
    check("ws_rdata",    HRDATA, 32'h5000_0002);
    tick();
    check("ws_next_mas", HMAS, 3);
    HREQ = '0;
    tick();
    tick();
    check("ws_idle_mas", HMAS, 0);

    // Lock by master 2 with masters 0 and 3 competing
    HREQ  = 4'b1101;
    HLOCK = 4'b0100;
    tick();
    check("lk_mas_first",  HMAS,  2);
    check("lk_lock_first", MLOCK, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("lk_mas_held", HMAS,  2);
      check("lk_locked",   MLOCK, 1);
    end
    HLOCK = '0;
    tick();
    check("lk_unlock", MLOCK, 0);
    check("lk_next",   HMAS,  3);
    HREQ = '0;
    tick();
    tick();
    check("lk_idle_mas", HMAS, 0);

    // SPLIT of master 1
    HREQ = 4'b0010;
    tick();
    check("sp_mas1", HMAS, 1);
    tick();
    HREQ = 4'b1010;
    set_resp(1, 2'b11);
    #1 check("sp_resp", HRESP, 2'b11);
    tick();
    check("sp_rearb", HMAS, 3);
    set_resp(1, 2'b00);
    HREQ = 4'hF;
    tick();
    check("sp_skip_a", HMAS, 0);
    tick();
    check("sp_skip_b", HMAS, 2);
    HSPLIT = 4'b0010;
    tick();
    HSPLIT = '0;
    check("sp_unsplit_a", HMAS, 3);
    tick();
    check("sp_unsplit_b", HMAS, 0);
    tick();
    check("sp_regrant", HMAS, 1);

    // Coincident SPLIT completion and HSPLIT for master 1: set wins
    tick();
    check("co_mas", HMAS, 2);
    set_resp(1, 2'b11);
    HSPLIT = 4'b0010;
    #1 check("co_resp", HRESP, 2'b11);
    tick();
    HSPLIT = '0;
    set_resp(1, 2'b00);
    check("co_mas_a", HMAS, 3);
    tick();
    check("co_mas_b", HMAS, 0);
    tick();
    check("co_masked", HMAS, 2);

    // Reset asserted during a stalled data phase
    HREQ = 4'b0100;
    tick();
    check("rm_mas", HMAS, 2);
    HREADY_S = 4'b1011;
    #1;
    check("rm_ready_lo", HREADY, 0);
    check("rm_rdata",    HRDATA, 32'h5000_0002);
    #2 RST = 1'b1;
    #1;
    check("rm_grant", HGRANT, 4'b0001);
    check("rm_mas0",  HMAS,   0);
    check("rm_lock",  MLOCK,  0);
    check("rm_ready", HREADY, 1);
    check("rm_resp",  HRESP,  0);
    check("rm_rd0",   HRDATA, 0);
    check("rm_sel",   HSEL,   0);
    tick();
    RST = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
